// File: rtl/jtag_dtm_sync_if.sv
// DMI request/response channel between the JTAG DTM (master) and the debug module (slave).
interface jtag_dtm_sync_if #(
    parameter int unsigned ABITS = 7
);
    logic             dmi_req_valid;
    logic             dmi_req_ready;
    logic [ABITS-1:0] dmi_req_addr;
    logic [31:0]      dmi_req_data;
    logic [1:0]       dmi_req_op;
    logic             dmi_resp_valid;
    logic             dmi_resp_ready;
    logic [31:0]      dmi_resp_data;
    logic [1:0]       dmi_resp_op;

    modport master (
        output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
        input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_op
    );
    modport slave (
        input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
        output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_op
    );
endinterface

// File: rtl/jtag_dtm_sync.sv
// RISC-V 0.13 JTAG DTM with the JTAG pins oversampled in the clk domain.
// Define JTAG_TCK_FILTER_EN to add a 2-sample glitch filter on tck (edge latency 4 clk instead of 3).
module jtag_dtm_sync #(
    parameter int unsigned ABITS      = 7,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0DB3,
    parameter logic [4:0]  IR_RESET   = 5'h01
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tck_i,
    input  logic             tms_i,
    input  logic             tdi_i,
    output logic             tdo_o,
    jtag_dtm_sync_if.master  dmi
);
    localparam int unsigned DRW = ABITS + 34;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    logic [2:0]       tck_sync_q, tck_sync_d;
    logic [1:0]       tms_sync_q, tms_sync_d;
    logic [1:0]       tdi_sync_q, tdi_sync_d;
    tap_e             tap_q, tap_d, tap_nxt;
    logic [4:0]       ir_q, ir_d;
    logic [4:0]       ir_sh_q, ir_sh_d;
    logic [DRW-1:0]   dr_q, dr_d;
    logic             tdo_q, tdo_d;
    logic [1:0]       stat_q, stat_d;
    logic             busy_q, busy_d;
    logic             req_valid_q, req_valid_d;
    logic [ABITS-1:0] req_addr_q, req_addr_d;
    logic [31:0]      req_data_q, req_data_d;
    logic [1:0]       req_op_q, req_op_d;
    logic [31:0]      last_data_q, last_data_d;

    logic       tck_rise, tck_fall, tms, tdi, resp_fire, busy_r;
    logic [1:0] stat_r, upd_op;

`ifdef JTAG_TCK_FILTER_EN
    logic tck_flt_q, tck_flt_d;
    logic tck_stable;

    // A level is only accepted once two consecutive synchronized samples agree.
    always_comb begin
        tck_stable = (tck_sync_q[1] == tck_sync_q[2]);
        tck_rise   = tck_stable &  tck_sync_q[1] & ~tck_flt_q;
        tck_fall   = tck_stable & ~tck_sync_q[1] &  tck_flt_q;
        tck_flt_d  = tck_stable ? tck_sync_q[1] : tck_flt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tck_flt_q <= 1'b0;
        else          tck_flt_q <= tck_flt_d;
    end
`else
    always_comb begin
        tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
        tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
    end
`endif

    always_comb begin
        tap_nxt = tap_q;
        case (tap_q)
            TLR:    tap_nxt = tms ? TLR    : RTI;
            RTI:    tap_nxt = tms ? SEL_DR : RTI;
            SEL_DR: tap_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR: tap_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  tap_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: tap_nxt = tms ? UPD_DR : PAU_DR;
            PAU_DR: tap_nxt = tms ? EX2_DR : PAU_DR;
            EX2_DR: tap_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: tap_nxt = tms ? SEL_DR : RTI;
            SEL_IR: tap_nxt = tms ? TLR    : CAP_IR;
            CAP_IR: tap_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  tap_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: tap_nxt = tms ? UPD_IR : PAU_IR;
            PAU_IR: tap_nxt = tms ? EX2_IR : PAU_IR;
            EX2_IR: tap_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: tap_nxt = tms ? SEL_DR : RTI;
            default: tap_nxt = TLR;
        endcase
    end

    always_comb begin
        tck_sync_d  = {tck_sync_q[1:0], tck_i};
        tms_sync_d  = {tms_sync_q[0], tms_i};
        tdi_sync_d  = {tdi_sync_q[0], tdi_i};
        tms         = tms_sync_q[1];
        tdi         = tdi_sync_q[1];

        // Response is folded in first so a same-cycle Capture-DR sees the fresh data.
        resp_fire   = dmi.dmi_resp_valid & busy_q;
        busy_r      = busy_q & ~resp_fire;
        last_data_d = resp_fire ? dmi.dmi_resp_data : last_data_q;
        stat_r      = (resp_fire && dmi.dmi_resp_op == 2'd2 && stat_q == 2'd0) ? 2'd2 : stat_q;

        tap_d       = tap_q;
        ir_d        = (tap_q == TLR) ? IR_RESET : ir_q;
        ir_sh_d     = ir_sh_q;
        dr_d        = dr_q;
        tdo_d       = tdo_q;
        stat_d      = stat_r;
        busy_d      = busy_r;
        req_valid_d = req_valid_q & ~dmi.dmi_req_ready;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_op_d    = req_op_q;
        upd_op      = dr_q[1:0];

        if (tck_rise) begin
            tap_d = tap_nxt;
            case (tap_q)
                CAP_IR: ir_sh_d = 5'b00001;
                SH_IR:  ir_sh_d = {tdi, ir_sh_q[4:1]};
                CAP_DR: begin
                    dr_d = '0;
                    case (ir_q)
                        5'h01: dr_d[31:0] = IDCODE_VAL;
                        5'h10: dr_d[31:0] = {17'd0, 3'd1, stat_r, 6'(ABITS), 4'd1};
                        5'h11: dr_d = {req_addr_q, last_data_d, busy_r ? 2'd3 : stat_r};
                        default: dr_d = '0;
                    endcase
                end
                SH_DR: begin
                    case (ir_q)
                        5'h01, 5'h10: begin
                            dr_d       = '0;
                            dr_d[31:0] = {tdi, dr_q[31:1]};
                        end
                        5'h11: dr_d = {tdi, dr_q[DRW-1:1]};
                        default: begin
                            dr_d    = '0;
                            dr_d[0] = tdi;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        if (tck_fall) begin
            tdo_d = (tap_q == SH_DR) ? dr_q[0] : (tap_q == SH_IR) ? ir_sh_q[0] : 1'b0;
            if (tap_q == UPD_IR) ir_d = ir_sh_q;
            if (tap_q == UPD_DR && ir_q == 5'h10) begin
                if (dr_q[17]) begin
                    stat_d      = 2'd0;
                    busy_d      = 1'b0;
                    req_valid_d = 1'b0;
                end else if (dr_q[16]) begin
                    stat_d = 2'd0;
                end
            end
            if (tap_q == UPD_DR && ir_q == 5'h11 && (upd_op == 2'd1 || upd_op == 2'd2)) begin
                if (busy_r) begin
                    stat_d = 2'd3;
                end else if (stat_r == 2'd0) begin
                    req_addr_d  = dr_q[DRW-1:34];
                    req_data_d  = dr_q[33:2];
                    req_op_d    = upd_op;
                    req_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            tap_q       <= TLR;
            ir_q        <= IR_RESET;
            ir_sh_q     <= '0;
            dr_q        <= '0;
            tdo_q       <= 1'b0;
            stat_q      <= 2'd0;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
            last_data_q <= '0;
        end else begin
            tck_sync_q  <= tck_sync_d;
            tms_sync_q  <= tms_sync_d;
            tdi_sync_q  <= tdi_sync_d;
            tap_q       <= tap_d;
            ir_q        <= ir_d;
            ir_sh_q     <= ir_sh_d;
            dr_q        <= dr_d;
            tdo_q       <= tdo_d;
            stat_q      <= stat_d;
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_op_q    <= req_op_d;
            last_data_q <= last_data_d;
        end
    end

    assign tdo_o              = tdo_q;
    assign dmi.dmi_req_valid  = req_valid_q;
    assign dmi.dmi_req_addr   = req_addr_q;
    assign dmi.dmi_req_data   = req_data_q;
    assign dmi.dmi_req_op     = req_op_q;
    assign dmi.dmi_resp_ready = busy_q;
endmodule

// File: doc/jtag_dtm_sync.md
Name: jtag_dtm_sync

Overview:
- JTAG Debug Transport Module (RISC-V debug spec 0.13 DTM) sitting directly downstream of the SoC JTAG pins (tck_i/tms_i/tdi_i/tdo_o) and upstream of the core debug module.
- Oversamples the JTAG pins in the system clock domain, so the block has a single clock.
- Runs the 16-state TAP and the IDCODE/DTMCS/DMI/BYPASS data registers.
- Converts DMI scans into a valid/ready request/response handshake toward the debug module.

Parameters:
- ABITS, 7, DMI address width.
- IDCODE_VAL, 32'h1000_0DB3, IDCODE register value; bit 0 must be 1.
- IR_RESET, 5'h01, IR value loaded in Test-Logic-Reset.

Ports:
- clk  in  1  system clock; must be at least 8x tck_i frequency.
- reset_n  in  1  asynchronous active-low reset.
- tck_i  in  1  JTAG clock pin, asynchronous to clk.
- tms_i  in  1  JTAG mode select, asynchronous.
- tdi_i  in  1  JTAG data in, asynchronous.
- tdo_o  out  1  JTAG data out.
- dmi_req_valid  out  1  DMI request valid.
- dmi_req_ready  in  1  debug module accepts request.
- dmi_req_addr  out  ABITS  DMI address.
- dmi_req_data  out  32  DMI write data.
- dmi_req_op  out  2  1=read, 2=write.
- dmi_resp_valid  in  1  DMI response valid.
- dmi_resp_ready  out  1  DTM accepts response.
- dmi_resp_data  in  32  DMI read data.
- dmi_resp_op  in  2  0=ok, 2=failed.

Behaviour:
- Reset: all outputs 0, TAP=Test-Logic-Reset, IR=IR_RESET, dmistat=0, shift registers 0.
- Sync: tck/tms/tdi each pass through a 2-FF synchronizer; a third register on tck provides edge detection.
  - tck rise is recognised 3 clk cycles after the pin edge.
  - TMS/TDI are sampled from the synchronized copies on the same cycle as the rise.
- On recognised tck rise: advance TAP per IEEE 1149.1 and shift the selected DR or IR (LSB first, TDI into MSB).
- Five consecutive TMS=1 rises reach Test-Logic-Reset from any state; IR is reloaded to IR_RESET there.
- On recognised tck fall: tdo_o <= LSB of active shift reg in Shift-DR/Shift-IR, else tdo_o <= 0.
- IR is 5 bits. Capture-IR loads 5'b00001.
- Instruction decode:
  - 0x01 IDCODE.
  - 0x10 DTMCS.
  - 0x11 DMI.
  - 0x1F and all other values BYPASS (1 bit, captures 0).
- DTMCS read value:
  - bits[3:0]=1 (version).
  - bits[9:4]=ABITS.
  - bits[11:10]=dmistat.
  - bits[14:12]=1 (idle).
  - all other bits 0.
- DTMCS Update-DR:
  - bit16 (dmireset) clears dmistat.
  - bit17 (dmihardreset) clears dmistat and drops any pending request/response.
- DMI DR is ABITS+34 bits: {addr, data[31:0], op[1:0]}.
- DMI Capture-DR loads {last_addr, last_resp_data, dmistat}, or op=3 if a request is outstanding.
- DMI Update-DR:
  - op=1/2, no outstanding request, dmistat==0: latch addr/data/op and assert dmi_req_valid next cycle.
  - Request outstanding: dmistat <= 3 (sticky); the scan is ignored.
  - op=0 or 3: no request.
- Request handshake:
  - dmi_req_valid holds with stable payload until dmi_req_ready; it drops the cycle after acceptance.
  - A request is outstanding from valid assertion until a response is accepted.
- dmi_resp_ready=1 whenever a request is outstanding.
- On dmi_resp_valid & dmi_resp_ready: latch data; if resp_op==2 then dmistat <= 2 unless dmistat is already nonzero.
- A response arriving in the same cycle as a tck edge: both are processed; the response latch has priority for Capture-DR of that edge.
- reset_n assertion mid-scan or mid-transaction: immediate return to reset values; the outstanding request is abandoned.

Optional Feature:
- JTAG_TCK_FILTER_EN defined:
  - adds a glitch filter; a tck level change is accepted only after 2 consecutive identical synchronized samples.
  - edge latency becomes 4 clk cycles; 1-cycle tck pulses are ignored.
- Undefined: no filter; 3-cycle latency as above.

Test Plan:
- Reset, then 5x TMS=1 then Shift-DR with IR=IR_RESET, shift 32 bits -> tdo_o stream equals 32'h1000_0DB3 LSB first.
- IR=0x10, capture DTMCS -> shifted value 32'h0000_1071 (ABITS=7).
- IR=0x11, shift {addr=7'h10, data=32'hDEAD_BEEF, op=2}, Update-DR, dmi_req_ready held low 5 cycles -> dmi_req_valid stable with payload for 5 cycles; drops 1 cycle after ready.
- Read scan op=1 addr=7'h11, response data 32'h0000_0ABC op=0, next scan op=0 -> captured {7'h11, 32'h0000_0ABC, 2'b00}.
- Second DMI Update-DR while first request is unanswered -> no new dmi_req_valid, dmistat=3; DTMCS write with bit16=1 -> dmistat=0.
- reset_n low mid-Shift-DR -> tdo_o=0, dmi_req_valid=0, IR=0x01 immediately (asynchronous).
